// File: rtl/rf_arbiter_pkg.sv
// Shared types and default widths for the register-file arbiter.
// Width macros normally arrive from the RF defines; fallbacks keep this slice self-contained.
`ifndef RF_AWIDTH
`define RF_AWIDTH 8
`endif
`ifndef RF_WIDTH
`define RF_WIDTH 32
`endif
`ifndef RF_MASK
`define RF_MASK 4
`endif

package pkg_rf_arb;

    localparam int RF_ARB_PORTS = 2;
    localparam int RF_AW        = `RF_AWIDTH;
    localparam int RF_DW        = `RF_WIDTH;
    localparam int RF_MW        = `RF_MASK;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_t;

    typedef struct packed {
        logic             we;
        logic [RF_AW-1:0] addr;
        logic [RF_DW-1:0] wdata;
        logic [RF_MW-1:0] wmask;
    } rf_req_t;

endpackage

// File: rtl/rf_arbiter_pick.sv
// Combinational two-way winner select: the current owner overrides, otherwise
// round-robin on last_win (or fixed priority to port 0 when round-robin is off).
module rf_arb_pick
    import pkg_rf_arb::*;
#(
    parameter int RR_EN = 1
) (
    input  logic   req0,
    input  logic   req1,
    input  owner_t owner,
    input  logic   last_win,
    input  logic   force_rr,
    output logic   gnt0,
    output logic   gnt1
);

    logic use_rr;

    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        // force_rr lets the port starved by a forced release win even under fixed priority
        use_rr = (RR_EN != 0) || force_rr;
        case (owner)
            OWN_P0: gnt0 = req0;
            OWN_P1: gnt1 = req1;
            default: begin
                if (req0 && req1) begin
                    if (use_rr && !last_win) gnt1 = 1'b1;
                    else                     gnt0 = 1'b1;
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end
        endcase
    end

endmodule

// File: rtl/rf_arbiter.sv
// Shares the single-port config register file between the host (p0) and the
// readout engine (p1): one access per cycle, bounded locked bursts, 1-cycle read return.
module rf_arbiter
    import pkg_rf_arb::*;
#(
    parameter int AW        = RF_AW,
    parameter int DW        = RF_DW,
    parameter int MW        = RF_MW,
    parameter int MAX_BURST = 8,
    parameter int RR_EN     = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_lock,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    input  logic [MW-1:0] p0_wmask,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_lock,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    input  logic [MW-1:0] p1_wmask,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          mem_we,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [MW-1:0] mem_wmask,
    input  logic [DW-1:0] mem_rdata
);

    // Handshake: a beat transfers when pX_req && pX_gnt in the same cycle; gnt is
    // combinational and never raised without req; requesters hold fields until granted.

    localparam int CW = $clog2(MAX_BURST + 1);

    owner_t        owner, owner_nxt;
    logic [CW-1:0] burst_cnt, burst_cnt_nxt, cnt_inc;
    logic          last_win, last_win_nxt;
    logic          force_rr, force_rr_nxt;
    logic          rd_pend, rd_src;
    logic [DW-1:0] p0_hold, p1_hold;
    logic          pick0, pick1;
    logic          accept, win, win_lock;

    rf_arb_pick #(.RR_EN(RR_EN)) u_pick (
        .req0     (p0_req),
        .req1     (p1_req),
        .owner    (owner),
        .last_win (last_win),
        .force_rr (force_rr),
        .gnt0     (pick0),
        .gnt1     (pick1)
    );

    // Grant and request mux; nothing reaches the register file while reset is held.
    always_comb begin
        p0_gnt    = pick0 & ~rst;
        p1_gnt    = pick1 & ~rst;
        accept    = p0_gnt | p1_gnt;
        win       = p1_gnt;
        win_lock  = win ? p1_lock : p0_lock;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (p0_gnt) begin
            mem_we    = p0_we;
            mem_re    = ~p0_we;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
            mem_wmask = p0_wmask;
        end else if (p1_gnt) begin
            mem_we    = p1_we;
            mem_re    = ~p1_we;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
            mem_wmask = p1_wmask;
        end
    end

    // Ownership FSM: the first beat of a burst counts toward MAX_BURST.
    always_comb begin
        owner_nxt     = owner;
        burst_cnt_nxt = burst_cnt;
        last_win_nxt  = last_win;
        force_rr_nxt  = 1'b0;
        cnt_inc       = burst_cnt + CW'(1);
        if (accept) begin
            last_win_nxt = win;
            if (win_lock && (cnt_inc < CW'(MAX_BURST))) begin
                owner_nxt     = win ? OWN_P1 : OWN_P0;
                burst_cnt_nxt = cnt_inc;
            end else begin
                owner_nxt     = OWN_NONE;
                burst_cnt_nxt = '0;
                force_rr_nxt  = win_lock && (owner != OWN_NONE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= OWN_NONE;
            burst_cnt <= '0;
            last_win  <= 1'b1;
            force_rr  <= 1'b0;
            rd_pend   <= 1'b0;
            rd_src    <= 1'b0;
            p0_hold   <= '0;
            p1_hold   <= '0;
        end else begin
            owner     <= owner_nxt;
            burst_cnt <= burst_cnt_nxt;
            last_win  <= last_win_nxt;
            force_rr  <= force_rr_nxt;
            rd_pend   <= mem_re;
            rd_src    <= p1_gnt;
            if (p0_rvalid) p0_hold <= mem_rdata;
            if (p1_rvalid) p1_hold <= mem_rdata;
        end
    end

    // Read data passes straight through on the return cycle, otherwise the last value holds.
    always_comb begin
        p0_rvalid = rd_pend & ~rd_src & ~rst;
        p1_rvalid = rd_pend &  rd_src & ~rst;
        p0_rdata  = '0;
        p1_rdata  = '0;
        if (!rst) begin
            p0_rdata = p0_rvalid ? mem_rdata : p0_hold;
            p1_rdata = p1_rvalid ? mem_rdata : p1_hold;
        end
    end

endmodule

// File: tb/tb_rf_arbiter.sv
// Directed bench for rf_arbiter: a round-robin instance (MAX_BURST=8) plus a
// fixed-priority instance sharing the same stimulus.
module tb_rf_arbiter;
    import pkg_rf_arb::*;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk;
    logic          rst;
    logic          p0_req, p0_lock, p0_we;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic [MW-1:0] p0_wmask;
    logic          p1_req, p1_lock, p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic [MW-1:0] p1_wmask;
    logic [DW-1:0] mem_rdata;

    logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          mem_we, mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;

    logic          fp_p0_gnt, fp_p0_rvalid, fp_p1_gnt, fp_p1_rvalid;
    logic [DW-1:0] fp_p0_rdata, fp_p1_rdata;
    logic          fp_mem_we, fp_mem_re;
    logic [AW-1:0] fp_mem_addr;
    logic [DW-1:0] fp_mem_wdata;
    logic [MW-1:0] fp_mem_wmask;

    int checks   = 0;
    int failures = 0;

    rf_arbiter #(.AW(AW), .DW(DW), .MW(MW), .MAX_BURST(8), .RR_EN(1)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_lock(p0_lock), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_lock(p1_lock), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    rf_arbiter #(.AW(AW), .DW(DW), .MW(MW), .MAX_BURST(8), .RR_EN(0)) dut_fp (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_lock(p0_lock), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
        .p0_gnt(fp_p0_gnt), .p0_rvalid(fp_p0_rvalid), .p0_rdata(fp_p0_rdata),
        .p1_req(p1_req), .p1_lock(p1_lock), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
        .p1_gnt(fp_p1_gnt), .p1_rvalid(fp_p1_rvalid), .p1_rdata(fp_p1_rdata),
        .mem_we(fp_mem_we), .mem_re(fp_mem_re), .mem_addr(fp_mem_addr),
        .mem_wdata(fp_mem_wdata), .mem_wmask(fp_mem_wmask), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive0(input logic req, input logic lock, input logic we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [MW-1:0] wmask);
        p0_req = req; p0_lock = lock; p0_we = we;
        p0_addr = addr; p0_wdata = wdata; p0_wmask = wmask;
    endtask

    task automatic drive1(input logic req, input logic lock, input logic we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [MW-1:0] wmask);
        p1_req = req; p1_lock = lock; p1_we = we;
        p1_addr = addr; p1_wdata = wdata; p1_wmask = wmask;
    endtask

    task automatic idle();
        drive0(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive1(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin : stim
        logic [12:0] tbl_p1;
        logic [12:0] tbl_p0;
        logic        exp_g1, exp_g0, prev_g1;
        int          b;

        rst = 1'b1;
        mem_rdata = '0;
        idle();
        tick();
        // Request during reset must not be granted nor strobe memory.
        drive0(1'b1, 1'b0, 1'b1, 8'h07, 32'h1111_2222, 4'hf);
        settle();
        check("rst_p0_gnt", p0_gnt, 0);
        check("rst_mem_we", mem_we, 0);
        tick();

        rst = 1'b0;
        idle();
        settle();
        check("rst_owner", dut.owner, OWN_NONE);
        check("rst_last_win", dut.last_win, 1);
        check("rst_p0_rvalid", p0_rvalid, 0);
        check("rst_p1_rdata", p1_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_re", mem_re, 0);
        tick();

        // Contention, no lock: RR alternates starting with p0; fixed priority always p0.
        for (int i = 0; i < 4; i++) begin
            drive0(1'b1, 1'b0, 1'b1, 8'h01, 32'hAAAA_0000, 4'hf);
            drive1(1'b1, 1'b0, 1'b1, 8'h02, 32'hBBBB_0000, 4'h3);
            settle();
            check($sformatf("rr_p0_gnt_%0d", i), p0_gnt, (i % 2 == 0) ? 1 : 0);
            check($sformatf("rr_p1_gnt_%0d", i), p1_gnt, (i % 2 == 1) ? 1 : 0);
            check($sformatf("rr_mem_addr_%0d", i), mem_addr, (i % 2 == 0) ? 8'h01 : 8'h02);
            check($sformatf("fp_p0_gnt_%0d", i), fp_p0_gnt, 1);
            check($sformatf("fp_p1_gnt_%0d", i), fp_p1_gnt, 0);
            check($sformatf("fp_mem_addr_%0d", i), fp_mem_addr, 8'h01);
            tick();
        end

        // Single write from p0.
        idle();
        drive0(1'b1, 1'b0, 1'b1, 8'h03, 32'h0000_0055, 4'b0001);
        settle();
        check("wr_p0_gnt", p0_gnt, 1);
        check("wr_mem_we", mem_we, 1);
        check("wr_mem_re", mem_re, 0);
        check("wr_mem_addr", mem_addr, 8'h03);
        check("wr_mem_wdata", mem_wdata, 32'h0000_0055);
        check("wr_mem_wmask", mem_wmask, 4'b0001);
        tick();
        idle();
        settle();
        check("wr_no_p0_rvalid", p0_rvalid, 0);
        check("wr_no_p1_rvalid", p1_rvalid, 0);
        tick();

        // Single read from p1; a p0 write in the return cycle must not disturb it.
        drive1(1'b1, 1'b0, 1'b0, 8'h08, '0, '0);
        settle();
        check("rd_p1_gnt", p1_gnt, 1);
        check("rd_mem_re", mem_re, 1);
        check("rd_mem_addr", mem_addr, 8'h08);
        tick();
        idle();
        drive0(1'b1, 1'b0, 1'b1, 8'h05, 32'h0000_00AB, 4'hf);
        mem_rdata = 32'hCCCC_DDDD;
        settle();
        check("rd_p1_rvalid", p1_rvalid, 1);
        check("rd_p1_rdata", p1_rdata, 32'hCCCC_DDDD);
        check("rd_p0_rvalid", p0_rvalid, 0);
        check("rd_wr_mem_we", mem_we, 1);
        tick();
        idle();
        mem_rdata = 32'h1234_5678;
        settle();
        check("rd_p1_rvalid_drop", p1_rvalid, 0);
        check("rd_p1_rdata_hold", p1_rdata, 32'hCCCC_DDDD);
        tick();

        // Locked burst: p1 10 read beats (last unlocked), p0 writing from cycle 2.
        // Expected: p1 cycles 1-8, forced release gives p0 cycle 9, p1 cycles 10-11, p0 cycle 12.
        tbl_p1  = 13'b0_1101_1111_1110;
        tbl_p0  = 13'b1_0010_0000_0000;
        prev_g1 = 1'b0;
        b       = 0;
        for (int c = 1; c <= 12; c++) begin
            exp_g1 = tbl_p1[c];
            exp_g0 = tbl_p0[c];
            drive1(c <= 11, b != 9, 1'b0, 8'h10 + 8'(b), '0, '0);
            drive0(c >= 2, 1'b0, 1'b1, 8'h40, 32'h0000_000C, 4'hf);
            mem_rdata = 32'hA000_0000 | 32'(c);
            settle();
            check($sformatf("bu_p1_gnt_%0d", c), p1_gnt, exp_g1);
            check($sformatf("bu_p0_gnt_%0d", c), p0_gnt, exp_g0);
            check($sformatf("bu_p1_rvalid_%0d", c), p1_rvalid, prev_g1);
            if (prev_g1) check($sformatf("bu_p1_rdata_%0d", c), p1_rdata, 32'hA000_0000 | 32'(c));
            if (exp_g1)  check($sformatf("bu_mem_addr_%0d", c), mem_addr, 8'h10 + 8'(b));
            tick();
            if (exp_g1) b++;
            prev_g1 = exp_g1;
        end

        // Lock gap: p0 holds ownership while idle; p1 is blocked until p0 releases.
        idle();
        drive0(1'b1, 1'b1, 1'b1, 8'h20, 32'h0000_0001, 4'hf);
        settle();
        check("lg_p0_gnt_1", p0_gnt, 1);
        tick();
        for (int g = 2; g <= 3; g++) begin
            drive0(1'b0, 1'b0, 1'b0, '0, '0, '0);
            drive1(1'b1, 1'b0, 1'b0, 8'h30, '0, '0);
            settle();
            check($sformatf("lg_p1_blocked_%0d", g), p1_gnt, 0);
            check($sformatf("lg_mem_re_%0d", g), mem_re, 0);
            check($sformatf("lg_owner_%0d", g), dut.owner, OWN_P0);
            tick();
        end
        drive0(1'b1, 1'b0, 1'b1, 8'h21, 32'h0000_0002, 4'hf);
        settle();
        check("lg_p0_release", p0_gnt, 1);
        check("lg_p1_still_blocked", p1_gnt, 0);
        tick();
        drive0(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive1(1'b1, 1'b1, 1'b0, 8'h30, '0, '0);
        settle();
        check("lg_p1_gnt_after", p1_gnt, 1);
        tick();

        // Reset in the middle of a p1 locked read burst.
        drive1(1'b1, 1'b1, 1'b0, 8'h31, '0, '0);
        mem_rdata = 32'hBEEF_0001;
        settle();
        check("mr_p1_gnt", p1_gnt, 1);
        check("mr_p1_rvalid", p1_rvalid, 1);
        check("mr_owner", dut.owner, OWN_P1);
        tick();
        rst = 1'b1;
        drive0(1'b1, 1'b0, 1'b1, 8'h01, 32'h0000_00EE, 4'hf);
        drive1(1'b1, 1'b1, 1'b0, 8'h32, '0, '0);
        mem_rdata = 32'hBEEF_0002;
        settle();
        check("mr_rst_p1_gnt", p1_gnt, 0);
        check("mr_rst_p0_gnt", p0_gnt, 0);
        check("mr_rst_mem_re", mem_re, 0);
        check("mr_rst_mem_we", mem_we, 0);
        check("mr_rst_p1_rvalid", p1_rvalid, 0);
        tick();
        rst = 1'b0;
        idle();
        mem_rdata = 32'h0000_55AA;
        settle();
        check("mr_post_p1_rvalid", p1_rvalid, 0);
        check("mr_post_p1_rdata", p1_rdata, 0);
        check("mr_post_p0_rdata", p0_rdata, 0);
        check("mr_post_mem_addr", mem_addr, 0);
        check("mr_post_owner", dut.owner, OWN_NONE);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive0(1'b1, 1'b0, 1'b1, 8'h01, 32'h0000_0003, 4'hf);
            drive1(1'b1, 1'b0, 1'b1, 8'h02, 32'h0000_0004, 4'hf);
            settle();
            check($sformatf("mr_rr_p0_gnt_%0d", i), p0_gnt, (i == 0) ? 1 : 0);
            check($sformatf("mr_rr_p1_gnt_%0d", i), p1_gnt, (i == 1) ? 1 : 0);
            tick();
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_arbiter.md
Name: rf_arbiter

Overview:
- Two-port arbiter that shares the single-port configuration register file between the host side and the on-chip engine side.
- Host side is the SPI peripheral's memory interface, already synchronised into the clk domain. Engine side is the internal readout sequencer.
- Grants one access per cycle and forwards it to the register file.
- Supports locked bursts with a bounded length. Returns read data to the winning port with fixed latency.

Parameters:
- AW, `RF_AWIDTH, register file address width
- DW, `RF_WIDTH (32), data width
- MW, `RF_MASK (4), byte-mask width (one bit per byte of DW)
- MAX_BURST, 8, maximum consecutive locked beats per owner (>=1)
- RR_EN, 1, 1 = round-robin, 0 = fixed priority with port 0 highest

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- p0_req  in  1  host request valid
- p0_lock  in  1  host requests that ownership be kept after this beat
- p0_we  in  1  host write enable (0 = read)
- p0_addr  in  AW  host address
- p0_wdata  in  DW  host write data
- p0_wmask  in  MW  host byte mask
- p0_gnt  out  1  host request accepted this cycle
- p0_rvalid  out  1  host read data valid
- p0_rdata  out  DW  host read data
- p1_req, p1_lock, p1_we, p1_addr, p1_wdata, p1_wmask, p1_gnt, p1_rvalid, p1_rdata: same as the p0_* ports, for the engine
- mem_we  out  1  register file write strobe
- mem_re  out  1  register file read strobe
- mem_addr  out  AW  register file address
- mem_wdata  out  DW  register file write data
- mem_wmask  out  MW  register file byte mask
- mem_rdata  in  DW  register file read data, valid 1 cycle after mem_re

Behaviour:
- Reset:
  - All gnt, rvalid, mem_we and mem_re are 0.
  - All rdata, mem_addr, mem_wdata and mem_wmask are 0.
  - owner = NONE, burst_cnt = 0, last_win = 1 (so port 0 wins first), rd_pend = 0.
- Handshake:
  - A beat is accepted when pX_req & pX_gnt.
  - gnt is combinational from req and the registered state, and is never asserted without req.
  - A requester holds all its request fields stable until granted.
- Arbitration FSM, state owner in {NONE, P0, P1}:
  - NONE, single requester: that requester wins.
  - NONE, both request, RR_EN=1: the port != last_win wins.
  - NONE, both request, RR_EN=0: port 0 wins.
  - P0/P1: the owner is granted whenever it requests. The other port is blocked even if the owner's req is low.
  - Transition to owner=X: accepted beat with pX_lock=1 and burst_cnt+1 < MAX_BURST.
  - Transition to owner=NONE: accepted beat with pX_lock=0, or burst_cnt+1 == MAX_BURST (forced release).
  - burst_cnt increments on each accepted beat while owned. It clears on return to NONE and on a new owner.
  - last_win updates to the granted port on every accepted beat.
  - After a forced release with the other port requesting, the other port wins the next cycle regardless of RR_EN.
  - MAX_BURST=1: lock is ignored and owner never leaves NONE.
- Datapath:
  - mem_* fields mirror the granted port's fields in the same cycle (combinational mux).
  - mem_we = gnt & we; mem_re = gnt & ~we.
  - With no grant, mem_we = mem_re = 0 and mem_addr/wdata/wmask = 0.
- Read return:
  - A read accepted in cycle N gives pX_rvalid = 1 in cycle N+1, with pX_rdata = mem_rdata registered-through (combinational pass in N+1).
  - rd_src is captured at N. Only the originating port sees rvalid.
  - pX_rdata holds its last value when rvalid = 0.
  - Back-to-back reads yield rvalid every cycle.
  - A write in N+1 does not disturb the pending return.
- Reset mid-burst: owner, lock and pending rvalid are dropped. No mem strobe is issued in the reset cycle.

Decomposition:
- Shared package pkg_rf_arb:
  - typedef enum owner_t {OWN_NONE, OWN_P0, OWN_P1}
  - struct rf_req_t {we, addr, wdata, wmask}
  - constant RF_ARB_PORTS = 2
- Width macros come from the existing RF defines.
- One natural sub-module: rf_arb_pick. It is the combinational 2-way winner select (RR/priority, owner override). Keep the FSM, burst counter and read tracking in the top level.

Test Plan:
- Single write: p0 write addr 3, wdata 'h0000_0055, mask 'b0001 -> p0_gnt=1 same cycle; mem_we=1, mem_addr=3, mem_wmask=1; no rvalid.
- Single read: p1 read addr 8, mem_rdata='hCCCC_DDDD -> p1_rvalid=1 next cycle with 'hCCCCDDDD; p0_rvalid stays 0.
- Contention, RR_EN=1, both requesting continuously, no lock -> grants alternate p0,p1,p0,p1; first grant after reset is p0. With RR_EN=0 -> p0 granted every cycle.
- Locked burst, MAX_BURST=8: p1 reads 10 beats with lock=1 while p0 requests -> p1 gets 8 consecutive grants; p0 granted on cycle 9; p1 resumes after.
- Lock gap: p0 locks, drops req for 2 cycles, p1 requesting -> p1 gnt stays 0 throughout; p0's next beat with lock=0 releases, then p1 granted.
- Reset mid-burst: assert rst during the p1 read burst -> next cycle all outputs are 0 and owner is NONE; after release, p0 wins first under simultaneous requests.
